// File: rtl/opb_register_bank_if.sv
// OPB slave-side bus bundle for opb_register_bank.
// Carries the master-driven request signals (address, byte enables, write
// data, read-not-write, select, sequential hint) and the slave-driven
// responses (read data, acknowledge, and the unused error/retry/timeout
// lines). All vectors use OPB big-endian numbering: bit 0 is the MSB.
// The master modport drives requests; the slave modport drives responses.
interface opb_register_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank.sv
// OPB slave register bank with optional shadow/commit mode.
// Ports:
//   OPB_Clk        - sole clock, all logic on the rising edge
//   OPB_Rst_n      - asynchronous active-low reset
//   bus            - OPB slave modport (request in, response out)
//   user_data_out  - active registers, reg i at [32i+31:32i]
//   user_strobe    - one-cycle pulse per active register update
// Register i sits at C_BASEADDR+4*i. The word right after the last register
// is the commit address; in shadow mode a write there copies every shadow
// register to its active copy. The rest of the decoded window is acked but
// reads zero and ignores writes. Every accepted transfer takes two cycles:
// request seen in IDLE, acknowledge in ACK, then back to IDLE.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR  = 32'h01108000,
  parameter logic [31:0] C_HIGHADDR  = 32'h011080FF,
  parameter int          C_NUM_REGS  = 4,
  parameter int          C_SHADOW    = 0,
  parameter logic [31:0] C_RESET_VAL = 32'h00000000
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  opb_register_bank_if.slave         bus,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_strobe
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr, wdata, offset, rdata_d, rdata_q;
  logic [3:0]  be;
  logic [29:0] word_idx;
  logic        in_range, is_reg, is_commit;
  logic        start, wr_start, rd_start;
  logic        unused_bits;
  logic [31:0] active_q [C_NUM_REGS];
  logic [31:0] shadow_q [C_NUM_REGS];

  // Bus vectors are big-endian numbered; copying them into [31:0] vectors
  // keeps the numeric value, so BE[0] lands on be[3] and guards wdata[31:24].
  assign addr  = bus.OPB_ABus;
  assign wdata = bus.OPB_DBus;
  assign be    = bus.OPB_BE;

  // The two low address bits drop out of the word index, so byte offsets
  // within a word all select the same register.
  assign offset    = addr - C_BASEADDR;
  assign word_idx  = offset[31:2];
  assign in_range  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign is_reg    = word_idx < 30'(C_NUM_REGS);
  assign is_commit = word_idx == 30'(C_NUM_REGS);

  // Requests are only taken in IDLE, which is what forces the idle cycle
  // between back-to-back acks when select is held.
  assign start    = (state_q == IDLE) && bus.OPB_select && in_range;
  assign wr_start = start && !bus.OPB_RNW;
  assign rd_start = start &&  bus.OPB_RNW;

  assign unused_bits = ^{offset[1:0], bus.OPB_seqAddr};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // ACK always falls back to IDLE, so an ack never lasts more than a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read source is the shadow copy; in direct mode that is the active copy.
  always_comb begin
    rdata_d = '0;
    if (is_reg) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (word_idx == 30'(i)) rdata_d = shadow_q[i];
      end
    end
  end

  // Read data is loaded only on the accepting edge, so it is non-zero only
  // during the ACK cycle of a read and is cleared again on the next edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)    rdata_q <= '0;
    else if (rd_start) rdata_q <= rdata_d;
    else               rdata_q <= '0;
  end

  generate
    if (C_SHADOW != 0) begin : g_shadow
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VAL;
        end else if (wr_start && is_reg) begin
          for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 30'(i)) shadow_q[i] <= merge_bytes(shadow_q[i], wdata, be);
          end
        end
      end
    end else begin : g_direct
      assign shadow_q = active_q;
    end
  endgenerate

  // Strobes default low every edge so each pulse is exactly one cycle wide.
  // A write with no byte enables still strobes its register in direct mode.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) active_q[i] <= C_RESET_VAL;
      user_strobe <= '0;
    end else begin
      user_strobe <= '0;
      if (wr_start) begin
        if (C_SHADOW != 0) begin
          if (is_commit) begin
            for (int i = 0; i < C_NUM_REGS; i++) active_q[i] <= shadow_q[i];
            user_strobe <= '1;
          end
        end else if (is_reg) begin
          for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 30'(i)) begin
              active_q[i]    <= merge_bytes(active_q[i], wdata, be);
              user_strobe[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = active_q[g];
  end

  assign bus.Sl_DBus    = rdata_q;
  assign bus.Sl_xferAck = (state_q == ACK);
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Testbench for opb_register_bank.
// Two instances share clock and reset: dut0 in direct mode with four
// registers, dut1 in shadow mode with two registers. Bus transfers come
// from vector tables; expected ack-cycle results are queued when a request
// is driven and compared by a monitor whenever the DUT acknowledges.
module tb_opb_register_bank;

  localparam logic [31:0] B0 = 32'h01108000;
  localparam logic [31:0] B1 = 32'h00002000;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strobe;
  } vec_t;

  typedef struct {
    int           tag;
    logic [31:0]  rdata;
    logic [3:0]   strobe;
    logic [127:0] user;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] user0;
  logic [3:0]   strobe0;
  logic [63:0]  user1;
  logic [1:0]   strobe1;

  int n_cmp;
  int n_fail;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model0 [4];
  logic [31:0] shadow1 [2];
  logic [31:0] active1 [2];
  vec_t        vecs0 [19];
  vec_t        vecs1 [9];

  opb_register_bank_if bus0 ();
  opb_register_bank_if bus1 ();

  opb_register_bank #(
    .C_BASEADDR(B0), .C_HIGHADDR(32'h011080FF), .C_NUM_REGS(4),
    .C_SHADOW(0), .C_RESET_VAL(32'h00000000)
  ) dut0 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus0),
    .user_data_out(user0), .user_strobe(strobe0)
  );

  opb_register_bank #(
    .C_BASEADDR(B1), .C_HIGHADDR(32'h000020FF), .C_NUM_REGS(2),
    .C_SHADOW(1), .C_RESET_VAL(32'h00000000)
  ) dut1 (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus1),
    .user_data_out(user1), .user_strobe(strobe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rnw, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] data,
                              input logic ack, input logic [31:0] rd,
                              input logic [3:0] stb);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.be = be; v.data = data;
    v.exp_ack = ack; v.exp_rdata = rd; v.exp_strobe = stb;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] pack0();
    return {model0[3], model0[2], model0[1], model0[0]};
  endfunction

  function automatic logic [127:0] pack1();
    return {64'h0, active1[1], active1[0]};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic sel, input vec_t v);
    if (which == 0) begin
      bus0.OPB_select = sel; bus0.OPB_RNW = v.rnw; bus0.OPB_ABus = v.addr;
      bus0.OPB_BE = v.be; bus0.OPB_DBus = v.data;
    end else begin
      bus1.OPB_select = sel; bus1.OPB_RNW = v.rnw; bus1.OPB_ABus = v.addr;
      bus1.OPB_BE = v.be; bus1.OPB_DBus = v.data;
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 4; i++) model0[i] = 32'h0;
    for (int i = 0; i < 2; i++) begin shadow1[i] = 32'h0; active1[i] = 32'h0; end
  endtask

  // Drive one transfer. Accepted transfers queue their expected ack-cycle
  // results; rejected ones hold select for ten cycles and count acks.
  task automatic apply_stimulus(input int which, input int tag, input vec_t v);
    exp_t        e;
    logic [31:0] off;
    int          acks;
    int          waited;
    @(negedge clk);
    drive(which, 1'b1, v);
    if (v.exp_ack) begin
      off = (v.addr - (which == 0 ? B0 : B1)) >> 2;
      if (which == 0) begin
        if (!v.rnw && off < 4) model0[off] = merge(model0[off], v.data, v.be);
        e.user = pack0();
      end else begin
        if (!v.rnw && off < 2) shadow1[off] = merge(shadow1[off], v.data, v.be);
        if (!v.rnw && off == 2) begin active1[0] = shadow1[0]; active1[1] = shadow1[1]; end
        e.user = pack1();
      end
      e.tag = tag; e.rdata = v.exp_rdata; e.strobe = v.exp_strobe;
      if (which == 0) q0.push_back(e); else q1.push_back(e);
      @(posedge clk);
      #1 drive(which, 1'b0, v);
      waited = 0;
      while (((which == 0) ? q0.size() : q1.size()) != 0 && waited < 6) begin
        @(negedge clk);
        #1 waited++;
      end
      check_output($sformatf("dut%0d_v%0d_ack_pending", which, tag),
                   128'((which == 0) ? q0.size() : q1.size()), 128'(0));
      if (which == 0) q0.delete(); else q1.delete();
    end else begin
      acks = 0;
      repeat (10) begin
        @(negedge clk);
        if ((which == 0) ? bus0.Sl_xferAck : bus1.Sl_xferAck) acks++;
      end
      drive(which, 1'b0, v);
      check_output($sformatf("dut%0d_v%0d_no_ack", which, tag), 128'(acks), 128'(0));
    end
  endtask

  // Monitor step for one DUT: an ack pops and checks the oldest expectation,
  // any other cycle must show zero read data and no strobe.
  task automatic watch(input int which);
    logic         ack;
    logic         has;
    logic [31:0]  rd;
    logic [3:0]   stb;
    logic [127:0] usr;
    exp_t         e;
    if (which == 0) begin
      ack = bus0.Sl_xferAck; rd = bus0.Sl_DBus; stb = strobe0; usr = user0;
      has = q0.size() != 0;
    end else begin
      ack = bus1.Sl_xferAck; rd = bus1.Sl_DBus; stb = {2'b00, strobe1}; usr = {64'h0, user1};
      has = q1.size() != 0;
    end
    if (ack) begin
      check_output($sformatf("dut%0d_ack_expected", which), 128'(ack), 128'(has));
      if (has) begin
        if (which == 0) e = q0.pop_front(); else e = q1.pop_front();
        check_output($sformatf("dut%0d_v%0d_rdata", which, e.tag), 128'(rd), 128'(e.rdata));
        check_output($sformatf("dut%0d_v%0d_strobe", which, e.tag), 128'(stb), 128'(e.strobe));
        check_output($sformatf("dut%0d_v%0d_user", which, e.tag), usr, e.user);
      end
    end else begin
      check_output($sformatf("dut%0d_idle_dbus", which), 128'(rd), 128'(0));
      check_output($sformatf("dut%0d_idle_strobe", which), 128'(stb), 128'(0));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;
    exp_t e;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    v = mk(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive(0, 1'b0, v);
    drive(1, 1'b0, v);
    bus0.OPB_seqAddr = 1'b0;
    bus1.OPB_seqAddr = 1'b0;
    reset_models();

    // Direct-mode table: BE written in bus order BE[0:3].
    vecs0[0]  = mk(0, B0 + 32'h4,   4'b1111, 32'hDEADBEEF, 1, 32'h0, 4'b0010);
    vecs0[1]  = mk(1, B0 + 32'h4,   4'b1111, 32'h0,        1, 32'hDEADBEEF, 4'b0000);
    vecs0[2]  = mk(0, B0 + 32'h8,   4'b1111, 32'hAABBCCDD, 1, 32'h0, 4'b0100);
    vecs0[3]  = mk(0, B0 + 32'h8,   4'b0101, 32'h11223344, 1, 32'h0, 4'b0100);
    vecs0[4]  = mk(1, B0 + 32'h8,   4'b1111, 32'h0,        1, 32'hAA22CC44, 4'b0000);
    vecs0[5]  = mk(0, B0 + 32'hC,   4'b0000, 32'h12345678, 1, 32'h0, 4'b1000);
    vecs0[6]  = mk(1, B0 + 32'hC,   4'b1111, 32'h0,        1, 32'h0, 4'b0000);
    vecs0[7]  = mk(0, B0 + 32'h3,   4'b1111, 32'hCAFEF00D, 1, 32'h0, 4'b0001);
    vecs0[8]  = mk(1, B0 + 32'h2,   4'b1111, 32'h0,        1, 32'hCAFEF00D, 4'b0000);
    vecs0[9]  = mk(0, B0 + 32'h10,  4'b1111, 32'hFFFFFFFF, 1, 32'h0, 4'b0000);
    vecs0[10] = mk(1, B0 + 32'h10,  4'b1111, 32'h0,        1, 32'h0, 4'b0000);
    vecs0[11] = mk(0, B0 + 32'h40,  4'b1111, 32'hFFFFFFFF, 1, 32'h0, 4'b0000);
    vecs0[12] = mk(1, B0 + 32'h40,  4'b1111, 32'h0,        1, 32'h0, 4'b0000);
    vecs0[13] = mk(1, B0 + 32'hFC,  4'b1111, 32'h0,        1, 32'h0, 4'b0000);
    vecs0[14] = mk(1, B0 + 32'h100, 4'b1111, 32'h0,        0, 32'h0, 4'b0000);
    vecs0[15] = mk(0, B0 + 32'h100, 4'b1111, 32'hFFFFFFFF, 0, 32'h0, 4'b0000);
    vecs0[16] = mk(0, B0 - 32'h4,   4'b1111, 32'hFFFFFFFF, 0, 32'h0, 4'b0000);
    vecs0[17] = mk(1, B0 + 32'h4,   4'b1111, 32'h0,        1, 32'hDEADBEEF, 4'b0000);
    vecs0[18] = mk(1, B0,           4'b1111, 32'h0,        1, 32'hCAFEF00D, 4'b0000);

    // Shadow-mode table: writes stay invisible until the commit word.
    vecs1[0] = mk(0, B1,          4'b1111, 32'h00000001, 1, 32'h0, 4'b0000);
    vecs1[1] = mk(0, B1 + 32'h4,  4'b1111, 32'h00000002, 1, 32'h0, 4'b0000);
    vecs1[2] = mk(1, B1,          4'b1111, 32'h0,        1, 32'h00000001, 4'b0000);
    vecs1[3] = mk(1, B1 + 32'h4,  4'b1111, 32'h0,        1, 32'h00000002, 4'b0000);
    vecs1[4] = mk(0, B1 + 32'h8,  4'b1111, 32'h0,        1, 32'h0, 4'b0011);
    vecs1[5] = mk(1, B1 + 32'h8,  4'b1111, 32'h0,        1, 32'h0, 4'b0000);
    vecs1[6] = mk(0, B1,          4'b0011, 32'hFFFFFFFF, 1, 32'h0, 4'b0000);
    vecs1[7] = mk(1, B1,          4'b1111, 32'h0,        1, 32'h0000FFFF, 4'b0000);
    vecs1[8] = mk(1, B1 + 32'h4,  4'b1111, 32'h0,        1, 32'h00000002, 4'b0000);

    fork
      forever begin
        @(negedge clk);
        watch(0);
        watch(1);
      end
    join_none

    repeat (2) @(negedge clk);
    #1;
    check_output("reset_user0", user0, pack0());
    check_output("reset_user1", {64'h0, user1}, pack1());
    check_output("reset_ack0", 128'(bus0.Sl_xferAck), 128'(0));
    rst_n = 1'b1;

    $display("[TB] direct-mode vector table");
    for (int i = 0; i < 19; i++) apply_stimulus(0, i, vecs0[i]);

    $display("[TB] shadow-mode vector table");
    for (int i = 0; i < 9; i++) apply_stimulus(1, i, vecs1[i]);

    // Select held four cycles on a read: acks only in cycles 2 and 4.
    $display("[TB] held select sequence");
    @(negedge clk);
    drive(0, 1'b1, mk(1, B0, 4'b1111, 32'h0, 1, 32'h0, 4'b0000));
    e.tag = 100; e.rdata = 32'hCAFEF00D; e.strobe = 4'b0000; e.user = pack0();
    q0.push_back(e);
    e.tag = 101;
    q0.push_back(e);
    #1;
    check_output("hold_c1_ack", 128'(bus0.Sl_xferAck), 128'(0));
    check_output("hold_c1_dbus", 128'(bus0.Sl_DBus), 128'(0));
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("hold_c3_ack", 128'(bus0.Sl_xferAck), 128'(0));
    check_output("hold_c3_dbus", 128'(bus0.Sl_DBus), 128'(0));
    @(negedge clk);
    #1 bus0.OPB_select = 1'b0;
    @(negedge clk);
    #1;
    check_output("hold_after_ack", 128'(bus0.Sl_xferAck), 128'(0));
    check_output("hold_queue_drained", 128'(q0.size()), 128'(0));
    q0.delete();

    // Reset lands inside the accepting cycle of a write: nothing captured,
    // then the still-selected write is accepted on the first edge after release.
    $display("[TB] reset during transfer");
    @(negedge clk);
    drive(0, 1'b1, mk(0, B0 + 32'h4, 4'b1111, 32'h55555555, 1, 32'h0, 4'b0010));
    #2 rst_n = 1'b0;
    reset_models();
    #1;
    check_output("rst_async_user0", user0, pack0());
    check_output("rst_async_user1", {64'h0, user1}, pack1());
    @(posedge clk);
    @(negedge clk);
    #1;
    check_output("rst_no_ack", 128'(bus0.Sl_xferAck), 128'(0));
    check_output("rst_no_capture", user0, pack0());
    check_output("rst_strobe", 128'(strobe0), 128'(0));
    #1 rst_n = 1'b1;
    model0[1] = 32'h55555555;
    e.tag = 200; e.rdata = 32'h0; e.strobe = 4'b0010; e.user = pack0();
    q0.push_back(e);
    @(posedge clk);
    #1 bus0.OPB_select = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_release_ack", 128'(q0.size()), 128'(0));
    q0.delete();

    apply_stimulus(0, 300, mk(1, B0 + 32'h4, 4'b1111, 32'h0, 1, 32'h55555555, 4'b0000));
    apply_stimulus(0, 301, mk(1, B0, 4'b1111, 32'h0, 1, 32'h00000000, 4'b0000));
    apply_stimulus(1, 302, mk(1, B1, 4'b1111, 32'h0, 1, 32'h00000000, 4'b0000));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
